// File: rtl/vmask_expand.sv
// Expands packed v0 mask bits into per-beat byte-lane masks for the vector merge datapath.
// Optional VMASK_EXPAND_VM_BYPASS_EN adds in_vm: unmasked operations emit all-ones lanes without mask words.
module vmask_expand #(
    parameter int unsigned REQ_DATA_WIDTH = 64,
    parameter int unsigned MASK_WIDTH     = 8,
    parameter int unsigned SEW_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_start,
`ifdef VMASK_EXPAND_VM_BYPASS_EN
    input  logic                      in_vm,
`endif
    input  logic [SEW_WIDTH-1:0]      in_sew,
    input  logic [REQ_DATA_WIDTH-1:0] in_mask_word,
    input  logic                      in_mask_valid,
    output logic                      in_mask_ready,
    input  logic                      in_beat_valid,
    output logic                      in_beat_ready,
    output logic [MASK_WIDTH-1:0]     out_mask,
    output logic                      out_valid
);

    localparam int unsigned PTR_W = $clog2(REQ_DATA_WIDTH);

    logic [REQ_DATA_WIDTH-1:0] r_buf;
    logic                      r_full;
    logic [PTR_W-1:0]          r_ptr;
    logic [SEW_WIDTH-1:0]      r_sew;
    logic [MASK_WIDTH-1:0]     r_out_mask;
    logic                      r_out_valid;

    logic                      w_bypass;
    logic [PTR_W:0]            w_elems;
    logic [PTR_W:0]            w_ptr_end;
    logic                      w_end_of_word;
    logic                      w_beat_ready;
    logic                      w_fire;
    logic                      w_last;
    logic                      w_mask_ready;
    logic                      w_load;
    logic [MASK_WIDTH-1:0]     w_lane_mask;

`ifdef VMASK_EXPAND_VM_BYPASS_EN
    logic r_vm;
    assign w_bypass = r_vm;
`else
    assign w_bypass = 1'b0;
`endif

    // One element per 2^sew byte lanes, so a beat consumes MASK_WIDTH>>sew mask bits.
    assign w_elems       = (PTR_W+1)'(MASK_WIDTH >> r_sew);
    assign w_ptr_end     = {1'b0, r_ptr} + w_elems;
    assign w_end_of_word = (w_ptr_end == (PTR_W+1)'(REQ_DATA_WIDTH));

    assign w_beat_ready  = ~in_start & (w_bypass | r_full);
    assign w_fire        = in_beat_valid & w_beat_ready;
    assign w_last        = w_fire & ~w_bypass & w_end_of_word;
    assign w_mask_ready  = ~in_start & ~w_bypass & (~r_full | w_last);
    assign w_load        = in_mask_valid & w_mask_ready;

    always_comb begin
        w_lane_mask = '0;
        if (w_bypass) begin
            w_lane_mask = '1;
        end else begin
            for (int unsigned lane = 0; lane < MASK_WIDTH; lane++) begin
                w_lane_mask[lane] = r_buf[r_ptr + PTR_W'(lane >> r_sew)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_full      <= 1'b0;
            r_ptr       <= '0;
            r_sew       <= '0;
            r_out_mask  <= '0;
            r_out_valid <= 1'b0;
`ifdef VMASK_EXPAND_VM_BYPASS_EN
            r_vm        <= 1'b0;
`endif
        end else begin
            r_out_valid <= w_fire;
            r_out_mask  <= w_fire ? w_lane_mask : '0;
            if (in_start) begin
                r_full <= 1'b0;
                r_ptr  <= '0;
                r_sew  <= in_sew;
`ifdef VMASK_EXPAND_VM_BYPASS_EN
                r_vm   <= in_vm;
`endif
            end else if (w_load) begin
                // A load can coincide with the last beat of the old word; the refill wins.
                r_buf  <= in_mask_word;
                r_full <= 1'b1;
                r_ptr  <= '0;
            end else if (w_fire) begin
                r_ptr <= w_ptr_end[PTR_W-1:0];
                if (w_last) begin
                    r_full <= 1'b0;
                end
            end
        end
    end

    assign in_mask_ready = w_mask_ready;
    assign in_beat_ready = w_beat_ready;
    assign out_mask      = r_out_mask;
    assign out_valid     = r_out_valid;

endmodule

// File: tb/tb_vmask_expand.sv
// Scoreboard bench for vmask_expand: the driver queues hand-computed lane masks, a monitor pops them on out_valid.
module tb_vmask_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic [1:0]  in_sew;
    logic [63:0] in_mask_word;
    logic        in_mask_valid;
    logic        in_mask_ready;
    logic        in_beat_valid;
    logic        in_beat_ready;
    logic [7:0]  out_mask;
    logic        out_valid;
`ifdef VMASK_EXPAND_VM_BYPASS_EN
    logic        in_vm;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    vmask_expand #(
        .REQ_DATA_WIDTH(64),
        .MASK_WIDTH(8),
        .SEW_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_start(in_start),
`ifdef VMASK_EXPAND_VM_BYPASS_EN
        .in_vm(in_vm),
`endif
        .in_sew(in_sew),
        .in_mask_word(in_mask_word),
        .in_mask_valid(in_mask_valid),
        .in_mask_ready(in_mask_ready),
        .in_beat_valid(in_beat_valid),
        .in_beat_ready(in_beat_ready),
        .out_mask(out_mask),
        .out_valid(out_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller has already reached the negedge; this drives one beat and queues its lane mask.
    task automatic drive_beat(input logic [7:0] exp_mask, input logic exp_mready, input string name);
        in_beat_valid = 1'b1;
        #1;
        check({name, "_beat_ready"}, {63'd0, in_beat_ready}, 64'd1);
        check({name, "_mask_ready"}, {63'd0, in_mask_ready}, {63'd0, exp_mready});
        sb.push_back(exp_mask);
    endtask

    task automatic start_op(input logic [1:0] sew);
        @(negedge clk);
        in_start      = 1'b1;
        in_sew        = sew;
        in_beat_valid = 1'b0;
        #1;
        check("start_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        check("start_mask_ready", {63'd0, in_mask_ready}, 64'd0);
    endtask

    task automatic load_word(input logic [63:0] word);
        @(negedge clk);
        in_start      = 1'b0;
        in_mask_valid = 1'b1;
        in_mask_word  = word;
        #1;
        check("load_mask_ready", {63'd0, in_mask_ready}, 64'd1);
        check("load_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        @(negedge clk);
        in_mask_valid = 1'b0;
        #1;
        check("loaded_beat_ready", {63'd0, in_beat_ready}, 64'd1);
        check("loaded_mask_ready", {63'd0, in_mask_ready}, 64'd0);
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    check("out_mask", {56'd0, out_mask}, {56'd0, sb.pop_front()});
                end
            end else begin
                check("idle_out_mask", {56'd0, out_mask}, 64'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        n_fail++;
        summary();
        $finish;
    end

    initial begin
        logic [7:0] exp31 [8];
        exp31 = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst           = 1'b1;
        in_start      = 1'b0;
        in_sew        = 2'd0;
        in_mask_word  = '0;
        in_mask_valid = 1'b0;
        in_beat_valid = 1'b0;
`ifdef VMASK_EXPAND_VM_BYPASS_EN
        in_vm         = 1'b0;
`endif
        #2;
        check("rst_out_valid",   {63'd0, out_valid},     64'd0);
        check("rst_out_mask",    {56'd0, out_mask},      64'd0);
        check("rst_beat_ready",  {63'd0, in_beat_ready}, 64'd0);
        check("rst_mask_ready",  {63'd0, in_mask_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // sew=8b: two populated bytes then zeros; the 8th beat frees the buffer.
        start_op(2'd0);
        load_word(64'h0000_0000_0000_A55A);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive_beat(exp31[k], (k == 7), "sew0");
        end
        @(negedge clk);
        in_beat_valid = 1'b0;
        #1;
        check("sew0_empty_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        check("sew0_empty_mask_ready", {63'd0, in_mask_ready}, 64'd1);

        // sew=16b: nibble 0x6 -> 0x3C; refill on the 16th beat with no bubble.
        start_op(2'd1);
        load_word(64'hF000_0000_0000_0006);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                in_mask_valid = 1'b1;
                in_mask_word  = 64'h0000_0000_0000_0001;
            end
            drive_beat((k == 0) ? 8'h3C : ((k == 15) ? 8'hFF : 8'h00), (k == 15), "sew1");
        end
        @(negedge clk);
        in_mask_valid = 1'b0;
        drive_beat(8'h03, 1'b0, "sew1_refill");
        @(negedge clk);
        drive_beat(8'h00, 1'b0, "sew1_refill2");
        @(negedge clk);
        in_beat_valid = 1'b0;

        // sew=64b: one bit per beat, 64 beats drain exactly one word.
        start_op(2'd3);
        load_word(64'h8000_0000_0000_0001);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            drive_beat((k == 0 || k == 63) ? 8'hFF : 8'h00, (k == 63), "sew3");
        end
        @(negedge clk);
        in_beat_valid = 1'b0;
        #1;
        check("sew3_empty_beat_ready", {63'd0, in_beat_ready}, 64'd0);

        // in_start mid-word blocks the same-cycle beat and discards the buffer.
        start_op(2'd0);
        load_word(64'h0000_0000_0000_FF0F);
        @(negedge clk);
        drive_beat(8'h0F, 1'b0, "midstart");
        @(negedge clk);
        in_start = 1'b1;
        #1;
        check("midstart_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        @(negedge clk);
        in_start = 1'b0;
        #1;
        check("midstart_no_out_valid", {63'd0, out_valid},     64'd0);
        check("midstart_beat_ready2",  {63'd0, in_beat_ready}, 64'd0);
        check("midstart_mask_ready",   {63'd0, in_mask_ready}, 64'd1);
        @(negedge clk);
        in_mask_valid = 1'b1;
        in_mask_word  = 64'h0000_0000_0000_00C3;
        #1;
        check("midstart_load_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        @(negedge clk);
        in_mask_valid = 1'b0;
        drive_beat(8'hC3, 1'b0, "midstart_new");
        @(negedge clk);
        in_beat_valid = 1'b0;

        // Asynchronous reset between edges while a beat result is on the outputs.
        start_op(2'd0);
        load_word(64'h0000_0000_0000_00FF);
        @(negedge clk);
        drive_beat(8'hFF, 1'b0, "prerst");
        @(posedge clk);
        #1;
        check("prerst_out_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_mid_out_valid",  {63'd0, out_valid},     64'd0);
        check("rst_mid_out_mask",   {56'd0, out_mask},      64'd0);
        check("rst_mid_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_beat_ready", {63'd0, in_beat_ready}, 64'd0);
        repeat (3) @(negedge clk);
        in_beat_valid = 1'b0;

`ifdef VMASK_EXPAND_VM_BYPASS_EN
        // Unmasked operation: all-ones lanes without any mask word.
        in_vm = 1'b1;
        start_op(2'd0);
        @(negedge clk);
        in_start = 1'b0;
        in_vm    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_beat(8'hFF, 1'b0, "vm_bypass");
            @(negedge clk);
        end
        in_beat_valid = 1'b0;
        start_op(2'd0);
        @(negedge clk);
        in_start = 1'b0;
        #1;
        check("vm_off_beat_ready", {63'd0, in_beat_ready}, 64'd0);
`endif

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        summary();
        $finish;
    end

endmodule
